// File: rtl/pwm_pkg.sv
// Shared constants and mode type for the multi-channel PWM block.
package pwm_pkg;

    localparam int unsigned DEFAULT_WIDTH = 11;
    localparam int unsigned DEFAULT_NCH   = 4;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle of pwm_multi: the master drives the requested settings, the slave drives
// the PWM outputs and status.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH
);

    logic                 en;
    logic                 load;
    logic [WIDTH-1:0]     period_in;
    logic                 center_in;
    logic [NCH*WIDTH-1:0] duty_in;
    logic [NCH-1:0]       pwm_out;
    logic                 period_start;
    logic                 pending;

    modport master (
        output en, load, period_in, center_in, duty_in,
        input  pwm_out, period_start, pending
    );

    modport slave (
        input  en, load, period_in, center_in, duty_in,
        output pwm_out, period_start, pending
    );

endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: unsigned compare of the shared counter against this channel's active duty,
// followed by the output register.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);

    logic pwm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= en & (cnt < duty);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned counter with double-buffered period, mode and
// duty settings that switch over only at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_multi_if.slave  bus
);

    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic                 down_q, down_d;
    logic                 wrap;
    logic                 apply;
    logic                 period_start_q;
    logic                 pend_flag_q;
    logic [WIDTH-1:0]     act_period_q, pend_period_q;
    pwm_mode_e            act_mode_q, pend_mode_q;
    logic [NCH*WIDTH-1:0] act_duty_q, pend_duty_q;
    logic [NCH-1:0]       pwm_vec;

    always_comb begin
        cnt_d  = cnt_q;
        down_d = down_q;
        wrap   = 1'b0;
        if (!bus.en) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (act_period_q == '0) begin
            wrap = 1'b1;
        end else if (act_mode_q == EDGE) begin
            if (cnt_q >= act_period_q) wrap = 1'b1;
            else                       cnt_d = cnt_q + WIDTH'(1);
        end else if (!down_q) begin
            if (cnt_q < act_period_q) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else if (act_period_q == WIDTH'(1)) begin
                wrap = 1'b1;
            end else begin
                // Turn around below the top so P is visited once per period.
                cnt_d  = act_period_q - WIDTH'(1);
                down_d = 1'b1;
            end
        end else begin
            if (cnt_q <= WIDTH'(1)) wrap = 1'b1;
            else                    cnt_d = cnt_q - WIDTH'(1);
        end
        if (wrap) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end
    end

    // A disabled block adopts new settings every cycle, just like a wrap.
    assign apply = wrap | ~bus.en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            down_q         <= 1'b0;
            period_start_q <= 1'b0;
            pend_flag_q    <= 1'b0;
            act_period_q   <= '1;
            pend_period_q  <= '1;
            act_mode_q     <= EDGE;
            pend_mode_q    <= EDGE;
            act_duty_q     <= '0;
            pend_duty_q    <= '0;
        end else begin
            cnt_q          <= cnt_d;
            down_q         <= down_d;
            period_start_q <= bus.en & (cnt_q == '0);
            // Pending always mirrors the latest load so a later disable never resurrects old values.
            if (bus.load) begin
                pend_period_q <= bus.period_in;
                pend_mode_q   <= pwm_mode_e'(bus.center_in);
                pend_duty_q   <= bus.duty_in;
            end
            if (apply) begin
                pend_flag_q <= 1'b0;
                if (bus.load) begin
                    act_period_q <= bus.period_in;
                    act_mode_q   <= pwm_mode_e'(bus.center_in);
                    act_duty_q   <= bus.duty_in;
                end else begin
                    act_period_q <= pend_period_q;
                    act_mode_q   <= pend_mode_q;
                    act_duty_q   <= pend_duty_q;
                end
            end else if (bus.load) begin
                pend_flag_q <= 1'b1;
            end
        end
    end

    genvar k;
    for (k = 0; k < int'(NCH); k++) begin : g_chan
        pwm_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .cnt   (cnt_q),
            .duty  (act_duty_q[k*WIDTH +: WIDTH]),
            .pwm   (pwm_vec[k])
        );
    end

    assign bus.pwm_out      = pwm_vec;
    assign bus.period_start = period_start_q;
    assign bus.pending      = pend_flag_q;

endmodule
